// File: rtl/ghost_mode_ctrl_pkg.sv
// Shared ghost AI definitions: mode codes seen by the renderers and the movement logic,
// plus the state enum whose encodings are those codes.
package ghost_mode_ctrl_pkg;

  localparam int unsigned AI_TIMER_W = 6;

  localparam logic [3:0] AI_SCATTER    = 4'd0;
  localparam logic [3:0] AI_CHASE      = 4'd1;
  localparam logic [3:0] AI_FRIGHTENED = 4'd2;
  localparam logic [3:0] AI_HOUSE      = 4'd3;
  localparam logic [3:0] AI_DEAD       = 4'd8;

  typedef enum logic [3:0] {
    ST_SCATTER    = AI_SCATTER,
    ST_CHASE      = AI_CHASE,
    ST_FRIGHTENED = AI_FRIGHTENED,
    ST_HOUSE      = AI_HOUSE,
    ST_DEAD       = AI_DEAD
  } ai_state_e;

  // Modes that a power pellet can interrupt and that are later resumed.
  function automatic logic is_sched_mode(ai_state_e s);
    return (s == ST_SCATTER) || (s == ST_CHASE);
  endfunction

endpackage

// File: rtl/ghost_mode_ctrl_tick_prescaler.sv
// Divides the frame-rate enable by TICK_DIV; tick is combinational on the ce that completes a period.
// No backpressure; clr restarts the period from zero on the next clk edge.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = ce && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Ghost AI mode sequencer (house/scatter/chase/frightened/dead); outputs change one clk after the input.
// GHOST_SCHED_WAVES_EN enables the scatter/chase wave schedule; otherwise chase is permanent after house.
module ghost_mode_ctrl
  import ghost_mode_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 30,
  parameter int unsigned HOUSE_TIME   = 4,
  parameter int unsigned SCATTER_TIME = 14,
  parameter int unsigned CHASE_TIME   = 40,
  parameter int unsigned FRIGHT_TIME  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  frighten,
  input  logic                  eaten,
  input  logic                  at_home,
  output logic [3:0]            aiState,
  output logic [AI_TIMER_W-1:0] aiTimer
);

  localparam logic [AI_TIMER_W-1:0] T_HOUSE   = AI_TIMER_W'(HOUSE_TIME);
  localparam logic [AI_TIMER_W-1:0] T_SCATTER = AI_TIMER_W'(SCATTER_TIME);
  localparam logic [AI_TIMER_W-1:0] T_CHASE   = AI_TIMER_W'(CHASE_TIME);
  localparam logic [AI_TIMER_W-1:0] T_FRIGHT  = AI_TIMER_W'(FRIGHT_TIME);

  ai_state_e             state_q, state_nxt;
  logic [AI_TIMER_W-1:0] timer_q, timer_nxt;
  ai_state_e             svmode_q, svmode_nxt;
  logic [AI_TIMER_W-1:0] svtimer_q, svtimer_nxt;
  logic                  tick, clr, expire, dec, chase_perm;

`ifdef GHOST_SCHED_WAVES_EN
  logic [1:0] wave_q, wave_nxt;

  assign chase_perm = (wave_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wave_q <= 2'd0;
    else       wave_q <= wave_nxt;
  end
`else
  assign chase_perm = 1'b1;
`endif

  assign expire = tick && (timer_q == '0);
  assign dec    = tick && (timer_q != '0);
  assign clr    = (state_nxt != state_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HOUSE;
      timer_q   <= T_HOUSE;
      svmode_q  <= ST_SCATTER;
      svtimer_q <= '0;
    end else begin
      state_q   <= state_nxt;
      timer_q   <= timer_nxt;
      svmode_q  <= svmode_nxt;
      svtimer_q <= svtimer_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    timer_nxt   = timer_q;
    svmode_nxt  = svmode_q;
    svtimer_nxt = svtimer_q;
`ifdef GHOST_SCHED_WAVES_EN
    wave_nxt    = wave_q;
`endif
    case (state_q)
      ST_HOUSE: begin
        if (expire) begin
`ifdef GHOST_SCHED_WAVES_EN
          state_nxt = ST_SCATTER;
          timer_nxt = T_SCATTER;
`else
          state_nxt = ST_CHASE;
          timer_nxt = chase_perm ? '0 : T_CHASE;
`endif
        end else if (dec) begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      ST_SCATTER, ST_CHASE: begin
        if (frighten && is_sched_mode(state_q)) begin
          svmode_nxt  = state_q;
          svtimer_nxt = timer_q;
          state_nxt   = ST_FRIGHTENED;
          timer_nxt   = T_FRIGHT;
        end else if (state_q == ST_SCATTER && expire) begin
          state_nxt = ST_CHASE;
          timer_nxt = chase_perm ? '0 : T_CHASE;
        end else if (state_q == ST_CHASE && chase_perm) begin
          // Final chase: timer frozen at zero and never expires.
          timer_nxt = '0;
        end else if (expire) begin
          state_nxt = ST_SCATTER;
          timer_nxt = T_SCATTER;
`ifdef GHOST_SCHED_WAVES_EN
          wave_nxt  = wave_q + 2'd1;
`endif
        end else if (dec) begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      ST_FRIGHTENED: begin
        if (eaten) begin
          state_nxt = ST_DEAD;
          timer_nxt = '0;
        end else if (frighten) begin
          timer_nxt = T_FRIGHT;
        end else if (expire) begin
          state_nxt = svmode_q;
          timer_nxt = svtimer_q;
        end else if (dec) begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      ST_DEAD: begin
        timer_nxt = '0;
        if (at_home) begin
          state_nxt = svmode_q;
          timer_nxt = svtimer_q;
        end
      end
      default: begin
        state_nxt = ST_HOUSE;
        timer_nxt = T_HOUSE;
      end
    endcase
  end

  always_comb begin
    aiState = state_q;
    aiTimer = timer_q;
  end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Vector table plus scoreboard bench for ghost_mode_ctrl with small timing parameters.
module tb_ghost_mode_ctrl;

  typedef struct {
    logic       ce;
    logic       fr;
    logic       ea;
    logic       ah;
    logic [3:0] st;
    logic [5:0] tm;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       frighten = 1'b0;
  logic       eaten = 1'b0;
  logic       at_home = 1'b0;
  logic [3:0] aiState;
  logic [5:0] aiTimer;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  ghost_mode_ctrl #(
    .TICK_DIV     (2),
    .HOUSE_TIME   (1),
    .SCATTER_TIME (2),
    .CHASE_TIME   (3),
    .FRIGHT_TIME  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .frighten (frighten),
    .eaten    (eaten),
    .at_home  (at_home),
    .aiState  (aiState),
    .aiTimer  (aiTimer)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic c, logic f, logic e, logic h, logic [3:0] s, logic [5:0] t);
    vec_t v;
    v.ce = c; v.fr = f; v.ea = e; v.ah = h; v.st = s; v.tm = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] s, input logic [5:0] t);
    n_vec++;
    if (aiState !== s || aiTimer !== t) begin
      n_err++;
      $display("FAIL %s: got aiState=%0d aiTimer=%0d, expected aiState=%0d aiTimer=%0d",
               name, aiState, aiTimer, s, t);
    end
  endtask

  // Drive one clk of inputs, queue the expectation, compare after the edge.
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    ce = v.ce; frighten = v.fr; eaten = v.ea; at_home = v.ah;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    ce = 1'b0; frighten = 1'b0; eaten = 1'b0; at_home = 1'b0;
    e = exp_q.pop_front();
    check(name, e.st, e.tm);
  endtask

  task automatic pulse_ce();
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  initial begin
    // HOUSE: pulses ignored, prescaler needs two ce per tick, expiry at fourth ce.
    tbl.push_back(mk(0,0,1,0, 3,1));
    tbl.push_back(mk(0,1,0,0, 3,1));
    tbl.push_back(mk(0,1,1,0, 3,1));
    tbl.push_back(mk(1,0,0,0, 3,1));
    tbl.push_back(mk(1,0,0,0, 3,0));
    tbl.push_back(mk(0,0,0,0, 3,0));
    tbl.push_back(mk(1,0,0,0, 3,0));
`ifdef GHOST_SCHED_WAVES_EN
    tbl.push_back(mk(1,0,0,0, 0,2));
    tbl.push_back(mk(1,0,0,0, 0,2));
    tbl.push_back(mk(1,0,0,0, 0,1));
    tbl.push_back(mk(0,1,0,0, 2,2));
    tbl.push_back(mk(1,0,0,0, 2,2));
    tbl.push_back(mk(1,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0, 2,0));
    tbl.push_back(mk(1,0,0,0, 2,0));
    tbl.push_back(mk(1,0,0,0, 0,1));
    tbl.push_back(mk(1,0,0,0, 0,1));
    tbl.push_back(mk(1,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0, 2,2));
    tbl.push_back(mk(0,1,1,0, 8,0));
    tbl.push_back(mk(1,0,0,0, 8,0));
    tbl.push_back(mk(0,0,0,1, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0));
    tbl.push_back(mk(0,0,1,0, 0,0));
`else
    tbl.push_back(mk(1,0,0,0, 1,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,0, 1,0));
    tbl.push_back(mk(0,1,0,0, 2,2));
    tbl.push_back(mk(1,0,0,0, 2,2));
    tbl.push_back(mk(1,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0, 2,0));
    tbl.push_back(mk(0,1,0,0, 2,2));
    tbl.push_back(mk(1,0,0,0, 2,2));
    tbl.push_back(mk(1,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0, 2,1));
    tbl.push_back(mk(1,0,0,0, 2,0));
    tbl.push_back(mk(1,0,0,0, 2,0));
    tbl.push_back(mk(1,0,0,0, 1,0));
    tbl.push_back(mk(0,1,0,0, 2,2));
    tbl.push_back(mk(0,1,1,0, 8,0));
    tbl.push_back(mk(1,0,0,0, 8,0));
    tbl.push_back(mk(1,0,0,0, 8,0));
    tbl.push_back(mk(0,0,0,1, 1,0));
    tbl.push_back(mk(0,0,0,1, 1,0));
    tbl.push_back(mk(0,0,1,0, 1,0));
`endif
    // Leave the ghost in DEAD for the reset sequence.
    tbl.push_back(mk(0,1,0,0, 2,2));
    tbl.push_back(mk(0,0,1,0, 8,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 4'd3, 6'd1);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset while DEAD takes effect without a clk edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_in_dead", 4'd3, 6'd1);
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0,1,1,0, 3,1), "house_pulses");
    apply(mk(1,0,0,0, 3,1), "post_rst_ce1");
    apply(mk(1,0,0,0, 3,0), "post_rst_ce2");
    apply(mk(1,0,0,0, 3,0), "post_rst_ce3");
`ifdef GHOST_SCHED_WAVES_EN
    apply(mk(1,0,0,0, 0,2), "post_rst_ce4");
    repeat (70) pulse_ce();
`else
    apply(mk(1,0,0,0, 1,0), "post_rst_ce4");
`endif
    for (int i = 0; i < 40; i++) apply(mk(1,0,0,0, 1,0), $sformatf("perm_chase%0d", i));
    apply(mk(0,1,0,0, 2,2), "perm_chase_fright");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
